// File: rtl/circ_window_addr_gen_pkg.sv
// Shared definitions for the circular window address generator: FSM encodings
// and a width helper that stays valid for degenerate sizes.
package circ_window_addr_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/circ_mod_add.sv
// Combinational (a + b) mod SIZE. Optional macro ADDR_GEN_STRIDE_EN selects a
// true modulo; otherwise operands are known to sum below 2*SIZE.
module circ_mod_add #(
  parameter int SIZE = 16,
  parameter int W    = 8,
  parameter int OW   = 4
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [OW-1:0] sum
);

  logic [W:0] raw_s;

  assign raw_s = {1'b0, a} + {1'b0, b};

`ifdef ADDR_GEN_STRIDE_EN
  assign sum = OW'(raw_s % (W+1)'(SIZE));
`else
  assign sum = (raw_s >= (W+1)'(SIZE)) ? OW'(raw_s - (W+1)'(SIZE)) : OW'(raw_s);
`endif

endmodule

// File: rtl/circ_window_addr_gen.sv
// Circular base pointer emitting LANES wrapped indices per cycle, advanced under
// valid/ready, with a lap bit. Macro ADDR_GEN_STRIDE_EN adds a runtime stride input.
module circ_window_addr_gen
  import circ_window_addr_gen_pkg::*;
#(
  parameter  int SIZE  = 16,
  parameter  int LANES = 4,
  localparam int AW    = safe_clog2(SIZE),
  localparam int CW    = safe_clog2(LANES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                clr,
  input  logic                load,
  input  logic [AW-1:0]       load_val,
`ifdef ADDR_GEN_STRIDE_EN
  input  logic [AW-1:0]       stride,
`endif
  input  logic                adv_valid,
  input  logic [CW-1:0]       adv_num,
  output logic                adv_ready,
  output logic [AW*LANES-1:0] idx_out,
  output logic [AW-1:0]       base_out,
  output logic                lap,
  output logic                wrap,
  output logic                busy
);

  // Wide enough for base + LANES*(SIZE-1) without truncation.
  localparam int W = AW + CW + 1;

  state_e          state_r, state_nx_s;
  logic [AW-1:0]   base_r, base_nx_s;
  logic            lap_r, lap_nx_s;
  logic            wrap_r, wrap_nx_s;

  logic [AW-1:0]   stride_s;
  logic [CW-1:0]   adv_sat_s;
  logic [W-1:0]    inc_s;
  logic [W-1:0]    adv_raw_s;
  logic            adv_ovf_s;
  logic [AW-1:0]   adv_mod_s;
  logic [AW-1:0]   load_red_s;
  logic            adv_acc_s;

`ifdef ADDR_GEN_STRIDE_EN
  assign stride_s = stride;
`else
  assign stride_s = AW'(1'b1);
`endif

  assign adv_sat_s  = (adv_num > CW'(LANES)) ? CW'(LANES) : adv_num;
  assign inc_s      = W'(adv_sat_s) * W'(stride_s);
  assign adv_raw_s  = W'(base_r) + inc_s;
  assign adv_ovf_s  = (adv_raw_s >= W'(SIZE));
  assign adv_acc_s  = adv_valid && (state_r == ST_RUN);
  assign load_red_s = ({1'b0, load_val} >= (AW+1)'(SIZE))
                    ? AW'({1'b0, load_val} - (AW+1)'(SIZE)) : load_val;

  circ_mod_add #(.SIZE(SIZE), .W(W), .OW(AW)) u_base_add (
    .a   (W'(base_r)),
    .b   (inc_s),
    .sum (adv_mod_s)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [W-1:0] off_s;
    assign off_s = W'(g) * W'(stride_s);
    circ_mod_add #(.SIZE(SIZE), .W(W), .OW(AW)) u_lane_add (
      .a   (W'(base_r)),
      .b   (off_s),
      .sum (idx_out[AW*(g+1)-1 -: AW])
    );
  end

  // FSM next state; stop dominates start.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) state_nx_s = ST_RUN;
        else                state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop) state_nx_s = ST_IDLE;
        else      state_nx_s = ST_RUN;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Base/lap/wrap update with priority clr > load > accepted advance.
  always_comb begin
    base_nx_s = base_r;
    lap_nx_s  = lap_r;
    wrap_nx_s = 1'b0;
    if (clr) begin
      base_nx_s = '0;
      lap_nx_s  = 1'b0;
    end else if (load) begin
      base_nx_s = load_red_s;
    end else if (adv_acc_s) begin
      base_nx_s = adv_mod_s;
      if (adv_ovf_s) begin
        lap_nx_s  = ~lap_r;
        wrap_nx_s = 1'b1;
      end else begin
        lap_nx_s  = lap_r;
      end
    end else begin
      base_nx_s = base_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      base_r  <= '0;
      lap_r   <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      base_r  <= base_nx_s;
      lap_r   <= lap_nx_s;
      wrap_r  <= wrap_nx_s;
    end
  end

  assign adv_ready = (state_r == ST_RUN);
  assign busy      = (state_r == ST_RUN);
  assign base_out  = base_r;
  assign lap       = lap_r;
  assign wrap      = wrap_r;

endmodule

// File: tb/tb_circ_window_addr_gen.sv
// Bench for circ_window_addr_gen: SIZE=16 and SIZE=10 instances share stimulus
// and are checked against an arithmetic reference model.
module tb_circ_window_addr_gen;

  logic        clk = 1'b0;
  logic        rst, start, stop, clr, load, adv_valid;
  logic [3:0]  load_val;
  logic [2:0]  adv_num;
`ifdef ADDR_GEN_STRIDE_EN
  logic [3:0]  stride;
`endif

  logic        ready0, ready1, lap0, lap1, wrap0, wrap1, busy0, busy1;
  logic [15:0] idx0, idx1;
  logic [3:0]  base0, base1;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state, one entry per instance
  int sizes [2] = '{16, 10};
  int m_base[2];
  bit m_lap [2];
  bit m_wrap[2];
  bit m_run;

  always #5 clk = ~clk;

  circ_window_addr_gen #(.SIZE(16), .LANES(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .load(load),
    .load_val(load_val),
`ifdef ADDR_GEN_STRIDE_EN
    .stride(stride),
`endif
    .adv_valid(adv_valid), .adv_num(adv_num), .adv_ready(ready0), .idx_out(idx0),
    .base_out(base0), .lap(lap0), .wrap(wrap0), .busy(busy0)
  );

  circ_window_addr_gen #(.SIZE(10), .LANES(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .load(load),
    .load_val(load_val),
`ifdef ADDR_GEN_STRIDE_EN
    .stride(stride),
`endif
    .adv_valid(adv_valid), .adv_num(adv_num), .adv_ready(ready1), .idx_out(idx1),
    .base_out(base1), .lap(lap1), .wrap(wrap1), .busy(busy1)
  );

  function automatic int cur_stride();
`ifdef ADDR_GEN_STRIDE_EN
    return int'(stride);
`else
    return 1;
`endif
  endfunction

  function automatic logic [23:0] exp_vec(input int k);
    logic [15:0] l;
    int s;
    s = cur_stride();
    for (int i = 0; i < 4; i++) l[4*i +: 4] = 4'((m_base[k] + i * s) % sizes[k]);
    return {m_run, m_run, m_lap[k], m_wrap[k], 4'(m_base[k]), l};
  endfunction

  function automatic logic [23:0] obs_vec(input int k);
    if (k == 0) return {busy0, ready0, lap0, wrap0, base0, idx0};
    else        return {busy1, ready1, lap1, wrap1, base1, idx1};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_base[k] = 0; m_lap[k] = 1'b0; m_wrap[k] = 1'b0;
    end
    m_run = 1'b0;
  endtask

  // one clock: model consumes the inputs held across the edge
  task automatic tick();
    bit acc;
    int n, sum;
    @(posedge clk);
    acc = adv_valid && m_run;
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 1'b0;
      if (clr) begin
        m_base[k] = 0; m_lap[k] = 1'b0;
      end else if (load) begin
        m_base[k] = int'(load_val) % sizes[k];
      end else if (acc) begin
        n   = (adv_num > 3'd4) ? 4 : int'(adv_num);
        sum = m_base[k] + n * cur_stride();
        if (sum >= sizes[k]) begin
          m_base[k] = sum % sizes[k]; m_lap[k] = ~m_lap[k]; m_wrap[k] = 1'b1;
        end else begin
          m_base[k] = sum;
        end
      end
    end
    if (m_run) begin
      if (stop) m_run = 1'b0;
    end else if (start && !stop) begin
      m_run = 1'b1;
    end
    #1;
  endtask

  task automatic quiet();
    start = 1'b0; stop = 1'b0; clr = 1'b0; load = 1'b0;
    adv_valid = 1'b0; adv_num = 3'd0; load_val = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet();
`ifdef ADDR_GEN_STRIDE_EN
    stride = 4'd1;
`endif
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) $display("FAIL reset dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) $display("FAIL start_hold dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_load_wrap();
    load = 1'b1; load_val = 4'd14;
    tick();
    load = 1'b0; adv_valid = 1'b1; adv_num = 3'd4;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) $display("FAIL load14 dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      else n_pass++;
    end
    tick();
    adv_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) $display("FAIL adv4_wrap dut%0d c%0d: got %h want %h", k, c, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_size10();
    load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0;
    for (int step = 0; step < 3; step++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) $display("FAIL size10 dut%0d s%0d: got %h want %h", k, step, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
      adv_valid = (step < 2);
      adv_num   = (step == 0) ? 3'd2 : 3'd4;
      tick();
    end
    adv_valid = 1'b0;
  endtask

  task automatic test_priority();
    load = 1'b1; load_val = 4'd5;
    tick();
    clr = 1'b1; load = 1'b1; load_val = 4'd7; adv_valid = 1'b1; adv_num = 3'd3;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) $display("FAIL clr_prio dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      else n_pass++;
    end
    tick();
    load = 1'b0; adv_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) $display("FAIL load_prio dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      else n_pass++;
    end
  endtask

  task automatic test_stop_adv();
    load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0; stop = 1'b1; adv_valid = 1'b1; adv_num = 3'd3;
    tick();
    stop = 1'b0; adv_num = 3'd2;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) $display("FAIL stop_adv dut%0d c%0d: got %h want %h", k, c, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
      tick();
    end
    adv_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    adv_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      adv_num = 3'($urandom_range(0, 4));
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) $display("FAIL b2b dut%0d c%0d: got %h want %h", k, c, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
    end
    adv_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      start     = ($urandom_range(0, 15) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      clr       = ($urandom_range(0, 29) == 0);
      load      = ($urandom_range(0, 9) == 0);
      load_val  = 4'($urandom_range(0, 9));
      adv_valid = ($urandom_range(0, 3) != 0);
      adv_num   = 3'($urandom_range(0, 4));
`ifdef ADDR_GEN_STRIDE_EN
      stride    = 4'($urandom_range(1, 9));
`endif
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) $display("FAIL random dut%0d c%0d: got %h want %h", k, c, obs_vec(k), exp_vec(k));
        else n_pass++;
      end
    end
    quiet();
`ifdef ADDR_GEN_STRIDE_EN
    stride = 4'd1;
`endif
  endtask

  task automatic test_async_reset();
    start = 1'b1; load = 1'b1; load_val = 4'd9;
    tick();
    start = 1'b0; load = 1'b0; adv_valid = 1'b1; adv_num = 3'd4;
    tick();
    adv_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) $display("FAIL pre_rst dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      else n_pass++;
    end
    rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) $display("FAIL async_rst dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      else n_pass++;
    end
    #1 rst = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) $display("FAIL post_rst dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      else n_pass++;
    end
  endtask

`ifdef ADDR_GEN_STRIDE_EN
  task automatic test_stride();
    stride = 4'd3; start = 1'b1; load = 1'b1; load_val = 4'd13;
    tick();
    start = 1'b0; load = 1'b0; adv_valid = 1'b1; adv_num = 3'd2;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) $display("FAIL stride_lanes dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      else n_pass++;
    end
    tick();
    adv_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) $display("FAIL stride_adv dut%0d: got %h want %h", k, obs_vec(k), exp_vec(k));
      else n_pass++;
    end
    stride = 4'd1;
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_load_wrap();
    test_size10();
    test_priority();
    test_stop_adv();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef ADDR_GEN_STRIDE_EN
    test_stride();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
